// File: rtl/iter_divider_if.sv
// iter_divider_if
// Handshake and data bundle between the issue logic, the iterative divider
// and the writeback arbiter.
//   in_valid / in_ready      request handshake (issue side drives in_valid)
//   in_signed, in_word       operation mode bits, qualified by in_valid
//   dividend, divisor        XLEN-bit operands
//   out_valid / out_ready    result handshake (writeback side drives out_ready)
//   quotient, remainder      XLEN-bit results, qualified by out_valid
// master: the side issuing divides and consuming results.
// slave:  the divider itself.
interface iter_divider_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic            in_signed;
   logic            in_word;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;

   modport master (
      output in_valid, in_signed, in_word, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder
   );

   modport slave (
      input  in_valid, in_signed, in_word, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder
   );
endinterface

// File: rtl/iter_divider.sv
// iter_divider
// Multi-cycle restoring radix-2 integer divider. One operation in flight.
// Supports signed/unsigned operands, a half-width word mode whose results are
// sign-extended from bit XLEN/2-1, and RISC-V divide-by-zero results.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   flush   abort any in-flight operation; beats everything but reset
//   bus     iter_divider_if slave modport (request and result handshakes)
module iter_divider #(
   parameter int XLEN = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   iter_divider_if.slave bus
);

   localparam int HALF = XLEN / 2;
   localparam int CW   = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // Restoring shift register: {partial remainder (XLEN+1), dividend/quotient (XLEN)}
   logic [2*XLEN:0] acc;
   logic [XLEN-1:0] div_mag;
   logic [CW-1:0]   step;
   logic            word_op;
   logic            neg_quot;
   logic            neg_rem;
   logic [XLEN-1:0] quot_result;
   logic [XLEN-1:0] rem_result;

   logic            accept;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            sign_a;
   logic            sign_b;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            div_zero;
   logic [2*XLEN:0] acc_init;
   logic [XLEN-1:0] dz_rem;

   logic [2*XLEN:0] shifted;
   logic [XLEN:0]   upper;
   logic [2*XLEN:0] step_acc;
   logic [CW-1:0]   last_step;
   logic [XLEN-1:0] quot_fixed;
   logic [XLEN-1:0] rem_fixed;
   logic [XLEN-1:0] quot_final;
   logic [XLEN-1:0] rem_final;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.quotient  = quot_result;
   assign bus.remainder = rem_result;

   // Operand preparation at accept time. Word mode narrows each operand to the
   // low half and re-extends it, so the rest of the datapath only ever sees
   // XLEN-wide two's-complement or unsigned values. Magnitudes are taken here
   // so the core loop is purely unsigned; the most-negative value maps onto
   // itself, which is exactly its unsigned magnitude. A word-mode magnitude
   // fits in HALF bits, so it is pre-shifted into the top of the low half so
   // that HALF steps are enough to move every dividend bit into the upper part.
   always_comb begin
      accept = bus.in_valid && (state == IDLE) && !flush;
      if (bus.in_word) begin
         if (bus.in_signed) begin
            op_a = {{HALF{bus.dividend[HALF-1]}}, bus.dividend[HALF-1:0]};
            op_b = {{HALF{bus.divisor[HALF-1]}}, bus.divisor[HALF-1:0]};
         end else begin
            op_a = {{HALF{1'b0}}, bus.dividend[HALF-1:0]};
            op_b = {{HALF{1'b0}}, bus.divisor[HALF-1:0]};
         end
      end else begin
         op_a = bus.dividend;
         op_b = bus.divisor;
      end
      sign_a   = bus.in_signed && op_a[XLEN-1];
      sign_b   = bus.in_signed && op_b[XLEN-1];
      mag_a    = sign_a ? -op_a : op_a;
      mag_b    = sign_b ? -op_b : op_b;
      div_zero = (op_b == '0);
      acc_init = {{(XLEN+1){1'b0}}, (bus.in_word ? (mag_a << HALF) : mag_a)};
      dz_rem   = bus.in_word ? {{HALF{op_a[HALF-1]}}, op_a[HALF-1:0]} : op_a;
   end

   // One restoring step plus the sign and word-mode fix-up of its outcome.
   // The fix-up is only captured on the final step, letting the result
   // registers load on the same edge the FSM enters DONE.
   always_comb begin
      shifted  = acc << 1;
      upper    = shifted[2*XLEN:XLEN];
      step_acc = shifted;
      if (upper >= {1'b0, div_mag}) begin
         step_acc[2*XLEN:XLEN] = upper - {1'b0, div_mag};
         step_acc[0]           = 1'b1;
      end
      last_step  = word_op ? CW'(HALF - 1) : CW'(XLEN - 1);
      quot_fixed = neg_quot ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
      rem_fixed  = neg_rem ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
      quot_final = word_op ? {{HALF{quot_fixed[HALF-1]}}, quot_fixed[HALF-1:0]}
                           : quot_fixed;
      rem_final  = word_op ? {{HALF{rem_fixed[HALF-1]}}, rem_fixed[HALF-1:0]}
                           : rem_fixed;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Divide by zero bypasses CALC entirely; flush overrides
   // every other transition and returns to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = div_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (step == last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   // Datapath registers. On accept the mode, signs and operands are latched;
   // a zero divisor loads the architectural divide-by-zero results directly.
   // A flushed CALC leaves the result registers untouched (stale is allowed).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc         <= '0;
         div_mag     <= '0;
         step        <= '0;
         word_op     <= 1'b0;
         neg_quot    <= 1'b0;
         neg_rem     <= 1'b0;
         quot_result <= '0;
         rem_result  <= '0;
      end else if (accept) begin
         acc      <= acc_init;
         div_mag  <= mag_b;
         step     <= '0;
         word_op  <= bus.in_word;
         neg_quot <= sign_a ^ sign_b;
         neg_rem  <= sign_a;
         if (div_zero) begin
            quot_result <= '1;
            rem_result  <= dz_rem;
         end
      end else if ((state == CALC) && !flush) begin
         acc  <= step_acc;
         step <= step + 1'b1;
         if (step == last_step) begin
            quot_result <= quot_final;
            rem_result  <= rem_final;
         end
      end
   end

endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle restoring radix-2 integer divider for the execute stage. It is the parametrised successor of the fixed 64-bit unsigned shift divider. Added over that design: configurable width, signed and unsigned modes, a half-width "word" mode (RV64 DIVW/REMW style), RISC-V divide-by-zero and overflow results, valid/ready handshakes on both sides, and a pipeline flush. It sits between the issue logic and the writeback arbiter, and holds one operation in flight at a time.

## Interface
- XLEN, default 64: operand and result width. Must be even and ≥ 8.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  abort any in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  divider can accept; high only in IDLE
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_word  in  1  1 = operate on low XLEN/2 bits, sign-extend results
- dividend  in  XLEN  numerator
- divisor  in  XLEN  denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  XLEN  quotient result
- remainder  out  XLEN  remainder result

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE. Reset values: out_valid=0, quotient=0, remainder=0. in_ready is derived from state, so it is 1 once reset is released.
- Accept: in_valid && in_ready && !flush. Latch the mode bits and operands.
- Word mode: take the low N=XLEN/2 bits of each operand. Sign-extend them if in_signed, else zero-extend. Otherwise N=XLEN.
- Signed mode: divide the magnitudes.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Core: shift register of 2N+1 bits, initialised to {0, |dividend|}. One step per CALC cycle:
  - shift left by 1;
  - if the upper part ≥ |divisor|, subtract it and set the quotient LSB to 1.
- Step counter: exactly N steps, then go to DONE.
- Divide by zero: detected at accept. Skip CALC and go straight to DONE with quotient = all ones and remainder = dividend, both after word-mode truncation and extension.
- Signed overflow (most-negative / −1): handled by the normal path, no special case. Result must be quotient = most-negative value, remainder = 0.
- Word-mode outputs: the N-bit result sign-extended to XLEN from bit N−1, in both signed and unsigned mode.
- DONE: out_valid=1. quotient and remainder are stable until out_ready. On out_valid && out_ready, go to IDLE; out_valid=0 next cycle.
- flush: has priority over everything except reset. Any state goes to IDLE next cycle and out_valid=0. A request presented in the same cycle is not accepted. The result registers may hold stale data.
- Reset mid-operation: same as flush. Also clears quotient and remainder to 0.

## Timing
- Accept at edge T. CALC occupies cycles T+1 … T+N.
- out_valid rises at T+N+1:
  - T+65 for a full-width operation with XLEN=64;
  - T+33 for a word-mode operation.
- Divide by zero: out_valid at T+1.
- Result handshake at edge R: in_ready is high from R+1. A new request is accepted at the earliest at R+1, so there is no same-cycle back-to-back.
- Throughput: one operation per N+2 cycles with out_ready tied high.
- No combinational path from in_valid to in_ready. out_valid and the results are registered.

## Test plan
All cases use XLEN=64.
- Unsigned 100/7 → quotient 14, remainder 2. out_valid exactly 65 cycles after accept.
- Signed −7/2 → quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF. Signed 7/−2 → quotient −3, remainder 1.
- Unsigned 5/0 → quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5, out_valid one cycle after accept. Signed 0x8000_0000_0000_0000 / −1 → quotient 0x8000_0000_0000_0000, remainder 0.
- Word mode, signed: dividend 0x0000_0001_8000_0000, divisor 0xFFFF_FFFF_FFFF_FFFF → quotient 0xFFFF_FFFF_8000_0000, remainder 0, latency 33 cycles.
- Word mode, unsigned: 0xFFFF_FFFF / 2 → quotient 0x7FFF_FFFF, remainder 1.
- Backpressure: hold out_ready low for 10 cycles → outputs stable and in_ready low throughout. Handshake → in_ready high next cycle, and a back-to-back 1000/10 gives quotient 100.
- Flush at CALC step 20 → out_valid never rises, in_ready high next cycle, and the following 9/3 returns quotient 3, remainder 0. Reset asserted mid-CALC → all outputs 0.
